serial_adder_8bit: RTL

//  Bit-serial adder: wraps one full_adder cell with a carry flip-flop and operand shift registers.

---
 rtl/serial_adder_8bit_if.sv | 29 ++
 rtl/serial_adder_8bit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/serial_adder_8bit_if.sv
// Operand/result bundle for the bit-serial adder.
//   start        request, sampled only while the adder is idle
//   a, b, c_in   operands, captured when start is accepted
//   busy         adder is working on an operation or presenting its result
//   done         one-cycle pulse; sum/c_out carry the new result
//   sum, c_out   last completed result, held until the next completion
// master = requester side, slave = adder side.
interface serial_adder_8bit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out
  );
endinterface

// File: rtl/serial_adder_8bit.sv
// Bit-serial adder: one full-adder cell, a carry flip-flop and operand shift
// registers add a + b + c_in one bit per clock, LSB first.
//   clk   clock, all state changes on the rising edge
//   rst   synchronous reset, active-high
//   bus   serial_adder_8bit_if slave: start/a/b/c_in in, busy/done/sum/c_out out
// An accepted start at edge k yields done high in the cycle after edge
// k+WIDTH; the next start can be accepted at edge k+WIDTH+2.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_adder_8bit_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reg_a_q, reg_a_d;
  logic [WIDTH-1:0] reg_b_q, reg_b_d;
  // Only WIDTH-1 result bits need storing: the final bit comes straight from
  // the adder on the completing edge.
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fa_s, fa_co;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  full_adder u_fa (
    .a_i (reg_a_q[0]),
    .b_i (reg_b_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_co)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign res_next = {fa_s, res_q};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.busy  = (state_q != IDLE);
    bus.done  = (state_q == DONE);
    bus.sum   = sum_q;
    bus.c_out = c_out_q;
  end

  // Datapath next-state
  always_comb begin
    reg_a_d = reg_a_q;
    reg_b_d = reg_b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          reg_a_d = bus.a;
          reg_b_d = bus.b;
          carry_d = bus.c_in;
          res_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        reg_a_d = {1'b0, reg_a_q[WIDTH-1:1]};
        reg_b_d = {1'b0, reg_b_q[WIDTH-1:1]};
        res_d   = res_next[WIDTH-1:1];
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        // Outputs change only here, so partial results never appear.
        if (last_bit) begin
          sum_d   = res_next;
          c_out_d = fa_co;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a_q <= '0;
      reg_b_q <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
